// File: rtl/ingress_header_parser.sv
// rtl/ingress_header_parser.sv - Ethernet header parser on a zero-latency AXI-Stream passthrough.
// Optional 802.1Q tag handling is built when INGRESS_PARSER_VLAN_EN is defined.
module ingress_header_parser #(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep,
    input  logic                          axis_in_tlast,
    input  logic                          axis_in_tvalid,
    output logic                          axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
    output logic                          axis_out_tlast,
    output logic                          axis_out_tvalid,
    input  logic                          axis_out_tready,
    input  logic [47:0]                   mac_base,
    input  logic [15:0]                   config_etype,
    output logic [(2**AXIS_ID_WIDTH)-1:0] route_mask,
    output logic                          poisoned,
    output logic                          parsing_done,
    output logic                          next_is_config
);
    localparam int NUM_AXIS_ID = 2**AXIS_ID_WIDTH;
`ifdef INGRESS_PARSER_VLAN_EN
    localparam logic [15:0] VLAN_TPID = 16'h8100;
`endif

    typedef enum logic [1:0] {HDR0 = 2'd0, HDR1 = 2'd1, HDR2 = 2'd2, DONE = 2'd3} state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   hs;
    logic [47:0]            beat_mac;
    logic [47:0]            mac_q;
    logic [15:0]            hdr1_etype;
    logic [15:0]            etype;
    logic                   decide;
    logic                   dec_poison;
    logic                   dec_route_en;
    logic                   dec_cfg_en;
    logic [NUM_AXIS_ID-1:0] route_calc;
    logic                   unused_mac_lsb;

    assign axis_out_tdata  = axis_in_tdata;
    assign axis_out_tkeep  = axis_in_tkeep;
    assign axis_out_tlast  = axis_in_tlast;
    assign axis_out_tvalid = axis_in_tvalid;
    assign axis_in_tready  = axis_out_tready;

    assign hs         = axis_in_tvalid && axis_out_tready;
    assign beat_mac   = {axis_in_tdata[7:0],   axis_in_tdata[15:8],  axis_in_tdata[23:16],
                         axis_in_tdata[31:24], axis_in_tdata[39:32], axis_in_tdata[47:40]};
    assign hdr1_etype = {axis_in_tdata[39:32], axis_in_tdata[47:40]};
    // Station bits of the local base are replaced by the MAC's own station index.
    assign unused_mac_lsb = ^mac_base[AXIS_ID_WIDTH-1:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= HDR0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HDR0: if (hs && !axis_in_tlast) next_state = HDR1;
            HDR1: begin
                if (hs) begin
                    if (axis_in_tlast) begin
                        next_state = HDR0;
`ifdef INGRESS_PARSER_VLAN_EN
                    end else if (hdr1_etype == VLAN_TPID) begin
                        next_state = HDR2;
`endif
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            HDR2: if (hs) next_state = axis_in_tlast ? HDR0 : DONE;
            DONE: if (hs && axis_in_tlast) next_state = HDR0;
            default: next_state = HDR0;
        endcase
    end

    always_comb begin
        decide       = 1'b0;
        dec_poison   = 1'b0;
        dec_route_en = 1'b1;
        dec_cfg_en   = 1'b1;
        etype        = hdr1_etype;
        case (state)
            HDR0: begin
                if (hs && axis_in_tlast) begin
                    decide       = 1'b1;
                    dec_poison   = 1'b1;
                    dec_route_en = 1'b0;
                    dec_cfg_en   = 1'b0;
                end
            end
            HDR1: begin
                if (hs) begin
                    decide     = 1'b1;
                    dec_poison = axis_in_tlast && (axis_in_tkeep[5:4] != 2'b11);
`ifdef INGRESS_PARSER_VLAN_EN
                    // A tag defers the decision unless the frame ends inside it.
                    if (hdr1_etype == VLAN_TPID) begin
                        decide     = axis_in_tlast;
                        dec_poison = axis_in_tlast;
                        dec_cfg_en = 1'b0;
                    end
`endif
                end
            end
`ifdef INGRESS_PARSER_VLAN_EN
            HDR2: begin
                if (hs) begin
                    decide     = 1'b1;
                    etype      = {axis_in_tdata[7:0], axis_in_tdata[15:8]};
                    dec_poison = axis_in_tlast && (axis_in_tkeep[1:0] != 2'b11);
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        route_calc = '0;
        if (mac_q == 48'hFFFF_FFFF_FFFF) begin
            route_calc = '1;
        end else if (mac_q[47:AXIS_ID_WIDTH] == mac_base[47:AXIS_ID_WIDTH]) begin
            route_calc[mac_q[AXIS_ID_WIDTH-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mac_q <= '0;
        end else if (state == HDR0 && hs) begin
            mac_q <= beat_mac;
        end
    end

    // Results persist through the packet; sitting in HDR0 means the last packet has ended.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            route_mask     <= '0;
            next_is_config <= 1'b0;
            poisoned       <= 1'b0;
            parsing_done   <= 1'b0;
        end else if (decide) begin
            route_mask     <= dec_route_en ? route_calc : '0;
            next_is_config <= dec_cfg_en && (etype == config_etype);
            poisoned       <= dec_poison;
            parsing_done   <= 1'b1;
        end else if (state == HDR0) begin
            route_mask     <= '0;
            next_is_config <= 1'b0;
            poisoned       <= 1'b0;
            parsing_done   <= 1'b0;
        end
    end
endmodule

// File: doc/ingress_header_parser.md
INGRESS_HEADER_PARSER -- requirements
Module: ingress_header_parser

Interface
REQ-001 SHALL have parameter AXIS_BUS_WIDTH, default 64: data width in bits; 64 is the only supported value.
REQ-002 SHALL have parameter AXIS_ID_WIDTH, default 4: destination ID width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH.
REQ-003 SHALL have port aclk  input  1  clock; one clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports axis_in_tdata/tkeep/tlast/tvalid  input  64/8/1/1  AXI-Stream ingress; byte 0 of a beat is tdata[7:0].
REQ-006 SHALL have port axis_in_tready  output  1  ingress ready.
REQ-007 SHALL have ports axis_out_tdata/tkeep/tlast/tvalid  output  64/8/1/1  AXI-Stream egress.
REQ-008 SHALL have port axis_out_tready  input  1  egress ready.
REQ-009 SHALL have port mac_base  input  48  local MAC base; MAC byte 0 is mac_base[47:40].
REQ-010 SHALL have port config_etype  input  16  EtherType that marks configuration packets.
REQ-011 SHALL have port route_mask  output  NUM_AXIS_ID  one-hot or all-ones destination mask.
REQ-012 SHALL have ports poisoned, parsing_done, next_is_config  output  1 each  side-channel results.

Function
REQ-013 SHALL pass the stream through combinationally: axis_out_* = axis_in_*, axis_in_tready = axis_out_tready; zero latency, no buffering.
REQ-014 SHALL count a beat only on handshake (tvalid && tready); a stalled beat is never parsed twice.
REQ-015 SHALL implement FSM states HDR0, HDR1, HDR2, DONE; reset state HDR0.
REQ-016 HDR0: on handshake capture dest MAC bytes 0-5 from beat bytes 0-5; tlast -> set poisoned=1, parsing_done=1 next cycle, stay HDR0; else -> HDR1.
REQ-017 HDR1: on handshake take EtherType = {byte 12, byte 13} (beat bytes 4,5); evaluate REQ-019..REQ-021; -> DONE, or HDR0 if tlast.
REQ-018 Packet ending (tlast) in HDR1 with tkeep[5:4] != 2'b11 SHALL set poisoned=1.
REQ-019 Dest MAC == 48'hFFFF_FFFF_FFFF SHALL give route_mask all ones.
REQ-020 Dest MAC[47:AXIS_ID_WIDTH] == mac_base[47:AXIS_ID_WIDTH] SHALL give route_mask one-hot at bit MAC[AXIS_ID_WIDTH-1:0]; otherwise route_mask = 0 (downstream treats this as route error).
REQ-021 next_is_config SHALL be 1 iff EtherType == config_etype.
REQ-022 Results SHALL be registered: route_mask, next_is_config, poisoned and parsing_done=1 SHALL become valid the cycle after the deciding handshake.
REQ-023 Outputs SHALL hold stable from parsing_done rise until the cycle after the tlast handshake, then return to 0 (single-beat packet: held exactly one cycle).
REQ-024 DONE: ignore data; on tlast handshake -> HDR0.
REQ-025 A tlast handshake coinciding with the deciding beat SHALL still produce the one-cycle result pulse of REQ-023.
REQ-026 A packet beginning the cycle after a tlast handshake SHALL be parsed from HDR0 with no bubble required.

Reset
REQ-027 aresetn low SHALL immediately force state HDR0 and route_mask, poisoned, parsing_done, next_is_config to 0.
REQ-028 Reset mid-packet SHALL discard partial parse; the first beat after release is treated as byte 0.
REQ-029 Passthrough path SHALL be unaffected by reset (purely combinational).

Configuration
REQ-030 Macro INGRESS_PARSER_VLAN_EN SHALL enable 802.1Q handling.
REQ-031 With macro: EtherType 16'h8100 in HDR1 -> HDR2 without deciding; HDR2 takes EtherType = {byte 16, byte 17} (beat bytes 0,1) and decides per REQ-019..REQ-022; tlast in HDR1 after 0x8100 or tkeep[1:0] != 2'b11 in HDR2 with tlast -> poisoned=1.
REQ-032 Without macro: HDR2 unreachable (may be omitted); 16'h8100 compared as an ordinary EtherType.

Verification
REQ-033 mac_base=02:00:00:00:00:00, dest 02:00:00:00:00:03, etype 0x0800, 4 beats -> route_mask=16'h0008, next_is_config=0, parsing_done=1 cycle after beat 1, cleared cycle after beat 3.
REQ-034 config_etype=0x88B5, dest FF:FF:FF:FF:FF:FF, etype 0x88B5 -> route_mask=16'hFFFF, next_is_config=1.
REQ-035 Single-beat packet (tlast on beat 0) -> poisoned=1, parsing_done=1 for exactly one cycle, route_mask=0.
REQ-036 axis_out_tready toggled 1,0,0,1 randomly during header beats -> identical results to back-pressure-free run; passthrough data matches bit-for-bit.
REQ-037 aresetn asserted during beat 1 with tvalid high -> all outputs 0 immediately; next packet parsed correctly.
REQ-038 With INGRESS_PARSER_VLAN_EN: etype 0x8100, inner 0x88B5 -> next_is_config=1, parsing_done cycle after beat 2; without macro same packet -> next_is_config=0 after beat 1.
